// File: rtl/rr_arbiter8.sv
// rr_arbiter8 - round-robin arbiter sharing one downstream resource among
// eight requesters, with a bounded hold time per grant.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req[7:0]   request vector, bit i = requester i wants the resource
//   done       owner releases the resource (only looked at while BUSY)
//   gnt[7:0]   registered one-hot grant, zero when nobody owns the resource
//   gnt_id     binary index of the set gnt bit, 0 when gnt is zero
//   gnt_valid  high whenever gnt is nonzero
//   timeout    one-cycle pulse after a grant is revoked by the hold limit
//   dbg_busy   FSM state for debug (1 = BUSY, 0 = IDLE)
//
// Handshake: a requester raises req[i] and keeps it high until it sees
// gnt[i]. It then owns the resource for every cycle gnt[i] stays high.
// It gives the resource back by pulsing done or by dropping req[i]. If it
// does neither, the grant is revoked after MAX_HOLD cycles. Requests are
// never latched, so a req withdrawn before the arbiter samples it is lost.
// Every hand-over passes through exactly one IDLE cycle with gnt == 0.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout,
  output logic       dbg_busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // hold_cnt counts cycles already spent in BUSY beyond the grant cycle,
  // so reaching MAX_HOLD-1 means the grant has lasted MAX_HOLD cycles.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [2:0] owner, owner_n;
  logic [7:0] hold_cnt, hold_n;
  logic [7:0] gnt_n;
  logic [2:0] gnt_id_n;
  logic       valid_n;
  logic       timeout_n;

  logic [2:0] winner;
  logic [2:0] idx;
  logic       found;

  // Rotating-priority search: ptr, ptr+1, ... ptr+7 (3-bit wrap), first set
  // bit wins. winner is meaningless when req == 0 and is not used then.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    hold_n    = hold_cnt;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    valid_n   = gnt_valid;
    timeout_n = 1'b0;

    case (state)
      IDLE: begin
        if (req != 8'h00) begin
          owner_n  = winner;
          gnt_n    = 8'd1 << winner;
          gnt_id_n = winner;
          valid_n  = 1'b1;
          hold_n   = 8'd0;
          state_n  = BUSY;
        end
      end
      BUSY: begin
        // A voluntary release beats the hold limit, so a timeout is only
        // flagged when the owner still wants the resource.
        if (done || !req[owner] || (hold_cnt == HOLD_LAST)) begin
          gnt_n     = 8'h00;
          gnt_id_n  = 3'd0;
          valid_n   = 1'b0;
          ptr_n     = owner + 3'd1;
          state_n   = IDLE;
          timeout_n = !(done || !req[owner]);
        end else begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      owner     <= 3'd0;
      hold_cnt  <= 8'd0;
      gnt       <= 8'h00;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      gnt_valid <= valid_n;
      timeout   <= timeout_n;
    end
  end

  assign dbg_busy = (state == BUSY);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8. Two instances run in lockstep on the same
// stimulus: instance a with MAX_HOLD = 4 and instance b with MAX_HOLD = 1.
// A behavioural reference model tracks both instances cycle by cycle.
module tb_rr_arbiter8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] req  = 8'h00;
  logic       done = 1'b0;

  logic [7:0] gnt_a, gnt_b;
  logic [2:0] gnt_id_a, gnt_id_b;
  logic       gnt_valid_a, gnt_valid_b;
  logic       timeout_a, timeout_b;
  logic       dbg_busy_a, dbg_busy_b;

  rr_arbiter8 #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_a), .gnt_id(gnt_id_a), .gnt_valid(gnt_valid_a),
    .timeout(timeout_a), .dbg_busy(dbg_busy_a)
  );

  rr_arbiter8 #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_b), .gnt_id(gnt_id_b), .gnt_valid(gnt_valid_b),
    .timeout(timeout_b), .dbg_busy(dbg_busy_b)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // m_held counts cycles the current grant has been visible, including the
  // grant cycle. The grant is revoked once it has been visible m_max cycles.
  int m_max[2] = '{4, 1};
  int m_busy[2];
  int m_ptr[2];
  int m_owner[2];
  int m_held[2];
  int m_to[2];

  // Grant order of instance a, checked when gnt_valid_a rises.
  logic [2:0] exp_q[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_ptr[k] = 0; m_owner[k] = 0; m_held[k] = 0; m_to[k] = 0;
    end
  endtask

  task automatic model_step();
    int w;
    for (int k = 0; k < 2; k++) begin
      if (m_busy[k] == 0) begin
        m_to[k] = 0;
        if (req != 8'h00) begin
          w = -1;
          for (int n = 0; n < 8; n++)
            if (w < 0 && req[(m_ptr[k] + n) % 8]) w = (m_ptr[k] + n) % 8;
          m_owner[k] = w;
          m_busy[k]  = 1;
          m_held[k]  = 1;
          if (k == 0) exp_q.push_back(3'(w));
        end
      end else if (done || !req[m_owner[k]]) begin
        m_busy[k] = 0;
        m_ptr[k]  = (m_owner[k] + 1) % 8;
        m_to[k]   = 0;
      end else if (m_held[k] >= m_max[k]) begin
        m_busy[k] = 0;
        m_ptr[k]  = (m_owner[k] + 1) % 8;
        m_to[k]   = 1;
      end else begin
        m_held[k] = m_held[k] + 1;
        m_to[k]   = 0;
      end
    end
  endtask

  // Expected {gnt, gnt_id, gnt_valid, timeout} for instance k.
  function automatic logic [12:0] model_out(int k);
    logic [7:0] g;
    logic [2:0] id;
    g  = (m_busy[k] != 0) ? (8'd1 << m_owner[k]) : 8'h00;
    id = (m_busy[k] != 0) ? 3'(m_owner[k]) : 3'd0;
    return {g, id, (m_busy[k] != 0), (m_to[k] != 0)};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock; the model consumes the inputs present at the edge.
  // Returns 1 ns after the edge, where outputs are sampled and inputs change.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  // Mid-cycle reset pulse, released well before the next edge.
  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic go_idle();
    req = 8'h00; done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req = 8'h00; done = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #2;
    if ({gnt_a, gnt_id_a, gnt_valid_a, timeout_a} !== 13'd0) begin
      errors++;
      $display("FAIL reset_a: got gnt=%h id=%0d v=%b to=%b, want all zero",
               gnt_a, gnt_id_a, gnt_valid_a, timeout_a);
    end
    checks++;
    if ({gnt_b, gnt_id_b, gnt_valid_b, timeout_b} !== 13'd0) begin
      errors++;
      $display("FAIL reset_b: got gnt=%h id=%0d v=%b to=%b, want all zero",
               gnt_b, gnt_id_b, gnt_valid_b, timeout_b);
    end
    checks++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_grant();
    req = 8'b1000_0000;
    tick();
    if ({gnt_a, gnt_id_a, gnt_valid_a, timeout_a} !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_grant: got gnt=%h id=%0d v=%b to=%b, want gnt=80 id=7 v=1 to=0",
               gnt_a, gnt_id_a, gnt_valid_a, timeout_a);
    end
    checks++;
    done = 1'b1;
    tick();
    done = 1'b0;
    if ({gnt_a, gnt_valid_a} !== 9'd0) begin
      errors++;
      $display("FAIL single_release: got gnt=%h v=%b, want gnt=00 v=0", gnt_a, gnt_valid_a);
    end
    checks++;
    // ptr wrapped to 0, so requester 0 beats requester 7.
    req = 8'b1000_0001;
    tick();
    if (gnt_id_a !== 3'd0 || gnt_a !== 8'h01) begin
      errors++;
      $display("FAIL ptr_wrap: got gnt=%h id=%0d, want gnt=01 id=0", gnt_a, gnt_id_a);
    end
    checks++;
    go_idle();
  endtask

  task automatic test_round_robin();
    pulse_reset();
    req = 8'hFF; done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (gnt_id_a !== 3'(i % 8) || gnt_valid_a !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant_%0d: got id=%0d v=%b, want id=%0d v=1",
                 i, gnt_id_a, gnt_valid_a, i % 8);
      end
      checks++;
      if (gnt_id_b !== 3'(i % 8) || timeout_b !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant_b_%0d: got id=%0d to=%b, want id=%0d to=0",
                 i, gnt_id_b, timeout_b, i % 8);
      end
      checks++;
      done = 1'b1;
      tick();
      done = 1'b0;
      if (gnt_a !== 8'h00 || timeout_a !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap_%0d: got gnt=%h to=%b, want gnt=00 to=0", i, gnt_a, timeout_a);
      end
      checks++;
    end
    go_idle();
  endtask

  task automatic test_timeout();
    pulse_reset();
    req = 8'b0000_0100; done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (gnt_a !== 8'h04 || timeout_a !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle_%0d: got gnt=%h to=%b, want gnt=04 to=0", i, gnt_a, timeout_a);
      end
      checks++;
    end
    tick();
    if ({gnt_a, gnt_valid_a, timeout_a} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL forced_release: got gnt=%h v=%b to=%b, want gnt=00 v=0 to=1",
               gnt_a, gnt_valid_a, timeout_a);
    end
    checks++;
    tick();
    if ({gnt_a, gnt_id_a, timeout_a} !== {8'h04, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL regrant_after_timeout: got gnt=%h id=%0d to=%b, want gnt=04 id=2 to=0",
               gnt_a, gnt_id_a, timeout_a);
    end
    checks++;
    go_idle();
  endtask

  task automatic test_req_drop();
    pulse_reset();
    req = 8'b0000_1000; done = 1'b0;
    tick();
    if (gnt_id_a !== 3'd3) begin
      errors++;
      $display("FAIL drop_owner: got id=%0d, want id=3", gnt_id_a);
    end
    checks++;
    req = 8'b0010_0010;
    tick();
    if ({gnt_a, timeout_a} !== 9'd0) begin
      errors++;
      $display("FAIL drop_release: got gnt=%h to=%b, want gnt=00 to=0", gnt_a, timeout_a);
    end
    checks++;
    tick();
    if (gnt_id_a !== 3'd5 || gnt_a !== 8'h20) begin
      errors++;
      $display("FAIL drop_next: got gnt=%h id=%0d, want gnt=20 id=5", gnt_a, gnt_id_a);
    end
    checks++;
    go_idle();
  endtask

  task automatic test_async_reset();
    req = 8'b0100_0000; done = 1'b0;
    tick();
    if (gnt_id_a !== 3'd6) begin
      errors++;
      $display("FAIL arst_setup: got id=%0d, want id=6", gnt_id_a);
    end
    checks++;
    #2 rst = 1'b1;
    model_reset();
    #1;
    if ({gnt_a, gnt_id_a, gnt_valid_a, timeout_a} !== 13'd0) begin
      errors++;
      $display("FAIL arst_clear: got gnt=%h id=%0d v=%b to=%b, want all zero",
               gnt_a, gnt_id_a, gnt_valid_a, timeout_a);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    req = 8'hFF;
    tick();
    if (gnt_id_a !== 3'd0 || gnt_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL arst_regrant: got id=%0d v=%b, want id=0 v=1", gnt_id_a, gnt_valid_a);
    end
    checks++;
    go_idle();
  endtask

  task automatic test_done_at_limit();
    pulse_reset();
    req = 8'b0001_0000; done = 1'b0;
    repeat (4) tick();
    if (gnt_a !== 8'h10) begin
      errors++;
      $display("FAIL limit_setup: got gnt=%h, want gnt=10", gnt_a);
    end
    checks++;
    done = 1'b1;
    tick();
    done = 1'b0;
    if ({gnt_a, timeout_a} !== 9'd0) begin
      errors++;
      $display("FAIL done_at_limit: got gnt=%h to=%b, want gnt=00 to=0", gnt_a, timeout_a);
    end
    checks++;
    go_idle();
  endtask

  task automatic test_random();
    logic       prev_v;
    logic [2:0] exp_id;
    pulse_reset();
    exp_q.delete();
    prev_v = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 5))
        0:       req = 8'h00;
        1:       req = 8'd1 << $urandom_range(0, 7);
        2:       req = 8'($urandom_range(0, 255));
        default: req = req;
      endcase
      done = ($urandom_range(0, 5) == 0);
      tick();
      if ({gnt_a, gnt_id_a, gnt_valid_a, timeout_a} !== model_out(0)) begin
        errors++;
        $display("FAIL rand_a cycle %0d: got %h/%0d/%b/%b, want %h/%0d/%b/%b", c,
                 gnt_a, gnt_id_a, gnt_valid_a, timeout_a, model_out(0) >> 5,
                 model_out(0) >> 2 & 13'h7, model_out(0) >> 1 & 13'h1, model_out(0) & 13'h1);
      end
      checks++;
      if ({gnt_b, gnt_id_b, gnt_valid_b, timeout_b} !== model_out(1)) begin
        errors++;
        $display("FAIL rand_b cycle %0d: got %h/%0d/%b/%b, want %h/%0d/%b/%b", c,
                 gnt_b, gnt_id_b, gnt_valid_b, timeout_b, model_out(1) >> 5,
                 model_out(1) >> 2 & 13'h7, model_out(1) >> 1 & 13'h1, model_out(1) & 13'h1);
      end
      checks++;
      if (gnt_valid_a && !prev_v) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_order cycle %0d: got grant id=%0d, want no grant", c, gnt_id_a);
        end else begin
          exp_id = exp_q.pop_front();
          if (gnt_id_a !== exp_id) begin
            errors++;
            $display("FAIL rand_order cycle %0d: got id=%0d, want id=%0d", c, gnt_id_a, exp_id);
          end
        end
        checks++;
      end
      prev_v = gnt_valid_a;
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
        prev_v = 1'b0;
      end
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_queue: got %0d grants still expected, want 0", exp_q.size());
    end
    checks++;
    go_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_single_grant();
    test_round_robin();
    test_timeout();
    test_req_drop();
    test_async_reset();
    test_done_at_limit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by 500000 ns, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource between eight requesters. It is the control block in front of the 8-to-3 encoder datapath. It produces a registered one-hot grant plus the matching 3-bit encoded grant index. Fairness comes from a rotating priority pointer. A hold counter bounds how long any requester may own the resource.

## Interface
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  request vector; bit i = requester i wants the resource.
- done  input  1  current owner releases the resource; sampled only in BUSY.
- gnt  output  8  one-hot grant, registered; all zero when no owner.
- gnt_id  output  3  binary index of the set gnt bit; 0 when gnt is zero.
- gnt_valid  output  1  high whenever gnt is nonzero.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by the hold limit.

## Operation
- Internal state:
  - state: IDLE or BUSY.
  - ptr: 3 bits, highest-priority requester index.
  - hold_cnt: 8 bits.
  - owner: 3 bits.
- Selection is combinational from req and ptr. Search order is ptr, ptr+1, …, ptr+7, modulo 8. The first set bit wins.
- IDLE:
  - If req == 0, stay in IDLE with outputs zero.
  - Otherwise, on the clock edge: owner <= winner, gnt <= one-hot(winner), gnt_id <= winner, gnt_valid <= 1, hold_cnt <= 0, state <= BUSY.
- BUSY, evaluated every edge, first matching rule applies:
  1. done == 1 or req[owner] == 0: normal release.
  2. hold_cnt == MAX_HOLD-1: forced release, and timeout <= 1 for one cycle.
  3. Otherwise: hold_cnt <= hold_cnt + 1; gnt is unchanged.
- On any release (normal or forced):
  - gnt <= 0, gnt_id <= 0, gnt_valid <= 0.
  - ptr <= owner + 1, with 3-bit natural wrap (7 -> 0).
  - state <= IDLE.
- gnt never changes to another requester without passing through IDLE. There is exactly one dead cycle between grants.
- req bits of non-owners are ignored in BUSY.
- gnt_id always equals the 8-to-3 encoding of gnt. gnt is never multi-hot.

## Timing
- Reset (async, any time): state = IDLE, ptr = 0, owner = 0, hold_cnt = 0, gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0.
  - Outputs clear immediately, without waiting for a clock edge.
  - Reset during BUSY drops the grant with no timeout pulse.
- Grant latency: req rising while IDLE gives gnt on the next rising edge (1 cycle).
- A grant lasts at least 1 cycle and at most MAX_HOLD cycles. The hold-cycle count includes the grant cycle.
  - MAX_HOLD = 1 means every grant lasts exactly one cycle, with timeout pulsed at release. This applies unless done or a req drop releases the grant first, which takes precedence.
- done and a req drop in the same cycle as the hold limit: normal release, and timeout stays 0.
- timeout is high for the single cycle after the revoking edge, coinciding with gnt = 0.
- Back-to-back service: a requester holding req continuously is granted at most once per 8 grants when all others also request.
- Simultaneous new requests in IDLE are resolved strictly by ptr order. No request latching; a request withdrawn before sampling is lost.

## Test plan
- Reset then req = 8'b1000_0000 -> 1 cycle later gnt = 8'b1000_0000, gnt_id = 7, gnt_valid = 1. Then done = 1 -> gnt = 0 next cycle and ptr = 0.
- From reset, req = 8'hFF held with done pulsed one cycle after each grant -> gnt_id sequence 0,1,2,3,4,5,6,7,0, with one gnt = 0 cycle between each.
- MAX_HOLD = 4, req = 8'b0000_0100 held, done = 0 -> gnt held exactly 4 cycles, then gnt = 0 and timeout = 1 for one cycle. A new grant to requester 2 follows on the next edge.
- Owner 3 granted, then req[3] drops while req[5] and req[1] are high -> release, then gnt_id = 5 (ptr = 4 favours 5 over 1).
- Assert rst mid-grant (gnt_id = 6) between clock edges -> gnt, gnt_id, gnt_valid and timeout go 0 immediately. After rst drops with req = 8'hFF, gnt_id = 0.
- With MAX_HOLD = 4, done = 1 on the cycle hold_cnt reaches 3 -> normal release and timeout remains 0.
